// File: rtl/ib_pkg.sv
// Shared widths, flit type codes and helpers for the switch input buffer.
package ib_pkg;

  localparam int unsigned PKTW = 9;
  localparam int unsigned PORT = 3;

  localparam int unsigned DESTW    = $clog2(PORT + 1);
  localparam int unsigned DEST_LSB = 0;

  typedef logic [PKTW:0] flit_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'b00,
    T_BODY = 2'b01,
    T_HEAD = 2'b10,
    T_TAIL = 2'b11
  } ftype_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_TRANS
  } state_t;

  // One-hot output-port request for a decoded destination.
  function automatic logic [PORT:0] dest_onehot(input logic [DESTW-1:0] d);
    dest_onehot = {{PORT{1'b0}}, 1'b1} << d;
  endfunction

endpackage

// File: rtl/ib_if.sv
// Flit/request bundle between an input buffer and its upstream/arbiter side.
interface ib_if;
  import ib_pkg::*;

  logic            ack;
  flit_t           pkti;
  flit_t           pkto;
  logic            full;
  logic [PORT:0]   req;

  modport master (
    output ack,
    output pkti,
    input  pkto,
    input  full,
    input  req
  );

  modport slave (
    input  ack,
    input  pkti,
    output pkto,
    output full,
    output req
  );

endinterface

// File: rtl/ib_fifo.sv
// Circular flit FIFO; pointers carry a wrap bit to tell full from empty.
module ib_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] front,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  count;
  logic         wr_en;
  logic         rd_en;

  // Occupancy flags and the qualified push/pop strobes.
  always_comb begin
    count = wptr - rptr;
    empty = (wptr == rptr);
    full  = (count == (AW+1)'(DEPTH));
    rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a push is accepted even when full.
    wr_en = push && (!full || rd_en);
    front = mem[rptr[AW-1:0]];
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

  // Read/write pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ib.sv
// Switch input buffer: queues flits, requests the destination port, streams the packet on grant.
module ib
  import ib_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  ib_if.slave  bus
);

  state_t          state;
  state_t          nstate;
  flit_t           front;
  ftype_t          ftype;
  logic            empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic [PORT:0]   req_q;
  logic [PORT:0]   front_req;

  ib_fifo #(
    .DEPTH (DEPTH),
    .W     (PKTW + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.pkti),
    .front (front),
    .full  (fifo_full),
    .empty (empty)
  );

  // Decode of the front entry and the incoming flit.
  always_comb begin
    ftype     = ftype_t'(front[PKTW:PKTW-1]);
    front_req = dest_onehot(front[DEST_LSB +: DESTW]);
    push      = !rst && (bus.pkti[PKTW:PKTW-1] != T_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state and pop decision.
  always_comb begin
    nstate = state;
    pop    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          if (ftype == T_HEAD) begin
            nstate = S_REQ;
          end else begin
            pop = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.ack && !empty) begin
          pop    = 1'b1;
          nstate = S_TRANS;
        end
      end
      S_TRANS: begin
        if (bus.ack && !empty) begin
          pop = 1'b1;
          if (ftype == T_TAIL) begin
            nstate = S_IDLE;
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Latch the requested port when a head is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (state == S_IDLE && nstate == S_REQ) begin
      req_q <= front_req;
    end
  end

  // Output drive: request vector, outgoing flit and full flag.
  always_comb begin
    bus.req  = '0;
    bus.pkto = '0;
    bus.full = fifo_full && !rst;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          if (!empty && ftype == T_HEAD) begin
            bus.req = front_req;
          end
        end
        S_REQ, S_TRANS: begin
          bus.req = req_q;
          if (bus.ack && !empty) begin
            bus.pkto = front;
          end
        end
        default: bus.req = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ib.sv
// Directed bench for the switch input buffer.
module tb_ib;
  import ib_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ib_if bus ();

  ib #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  localparam flit_t H3 = 10'b10_00000011;
  localparam flit_t B0 = 10'b01_00000000;
  localparam flit_t B1 = 10'b01_00000001;
  localparam flit_t B2 = 10'b01_00000010;
  localparam flit_t B3 = 10'b01_00000011;
  localparam flit_t T0 = 10'b11_00000000;
  localparam flit_t H1 = 10'b10_00000001;
  localparam flit_t T1 = 10'b11_00000001;
  localparam flit_t G0 = 10'b10_00000010;
  localparam flit_t G1 = 10'b01_10101010;
  localparam flit_t G2 = 10'b11_11001100;
  localparam flit_t K0 = 10'b10_00000000;
  localparam flit_t K1 = 10'b11_00001111;
  localparam flit_t P0 = 10'b10_00000001;
  localparam flit_t P1 = 10'b01_00000111;
  localparam flit_t P2 = 10'b01_00001000;
  localparam flit_t P3 = 10'b11_00001001;
  localparam flit_t XD = 10'b01_11111111;

  flit_t fill [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] req_e, input flit_t pkto_e,
                         input logic full_e);
    chk({tag, ".req"},  32'(bus.req),  32'(req_e));
    chk({tag, ".pkto"}, 32'(bus.pkto), 32'(pkto_e));
    chk({tag, ".full"}, 32'(bus.full), 32'(full_e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input flit_t p);
    bus.ack  = a;
    bus.pkti = p;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fill[0] = 10'b10_00000000;
    fill[1] = 10'b01_00010001;
    fill[2] = 10'b01_00100010;
    fill[3] = 10'b01_00110011;
    fill[4] = 10'b01_01000100;
    fill[5] = 10'b01_01010101;
    fill[6] = 10'b01_01100110;
    fill[7] = 10'b11_01110111;

    // Reset for two edges.
    rst      = 1'b1;
    bus.ack  = 1'b0;
    bus.pkti = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk_out("reset", 4'b0000, '0, 1'b0);

    // Single packet to port 3, grant arrives late.
    rst = 1'b0;
    drive(1'b0, H3);   chk("p1.empty_req", 32'(bus.req), 32'(4'b0000));
    tick; drive(1'b0, B0); chk_out("p1.head_req", 4'b1000, '0, 1'b0);
    tick; drive(1'b0, B1); chk_out("p1.wait", 4'b1000, '0, 1'b0);
    tick; drive(1'b0, B2);
    tick; drive(1'b0, B3);
    tick; drive(1'b1, T0); chk_out("p1.head", 4'b1000, H3, 1'b0);
    tick; drive(1'b1, '0); chk("p1.b0", 32'(bus.pkto), 32'(B0));
    tick; chk("p1.b1", 32'(bus.pkto), 32'(B1));
    tick; chk("p1.b2", 32'(bus.pkto), 32'(B2));
    tick; chk("p1.b3", 32'(bus.pkto), 32'(B3));
    tick; chk_out("p1.tail", 4'b1000, T0, 1'b0);
    tick; chk_out("p1.after", 4'b0000, '0, 1'b0);

    // Grant held high over an empty FIFO, then a short packet to port 1.
    tick; drive(1'b1, H1); chk_out("p2.empty", 4'b0000, '0, 1'b0);
    tick; drive(1'b1, T1); chk_out("p2.req", 4'b0010, '0, 1'b0);
    tick; drive(1'b1, '0); chk_out("p2.head", 4'b0010, H1, 1'b0);
    tick; chk_out("p2.tail", 4'b0010, T1, 1'b0);
    tick; drive(1'b0, fill[0]); chk_out("p2.after", 4'b0000, '0, 1'b0);

    // Fill to full with no grant; a ninth flit is dropped.
    for (int i = 1; i < 8; i++) begin
      tick; drive(1'b0, fill[i]);
      chk("fill.full_low", 32'(bus.full), 32'(1'b0));
    end
    chk("fill.req", 32'(bus.req), 32'(4'b0001));
    tick; drive(1'b0, XD); chk_out("fill.full", 4'b0001, '0, 1'b1);
    tick; drive(1'b0, '0); chk("fill.drop", 32'(bus.full), 32'(1'b1));

    // Drain with push-while-full, queuing packets to port 2 then port 0 behind.
    tick; drive(1'b1, G0); chk_out("drain.f0", 4'b0001, fill[0], 1'b1);
    tick; drive(1'b1, G1); chk_out("drain.f1", 4'b0001, fill[1], 1'b1);
    tick; drive(1'b1, G2); chk_out("drain.f2", 4'b0001, fill[2], 1'b1);
    tick; drive(1'b1, K0); chk_out("drain.f3", 4'b0001, fill[3], 1'b1);
    tick; drive(1'b1, K1); chk_out("drain.f4", 4'b0001, fill[4], 1'b1);
    tick; drive(1'b1, '0); chk_out("drain.f5", 4'b0001, fill[5], 1'b1);
    tick; chk_out("drain.f6", 4'b0001, fill[6], 1'b0);
    tick; chk_out("drain.f7", 4'b0001, fill[7], 1'b0);

    // Back-to-back packets: port 2 then port 0.
    tick; chk_out("b2b.a_req", 4'b0100, '0, 1'b0);
    tick; chk_out("b2b.a0", 4'b0100, G0, 1'b0);
    tick; chk_out("b2b.a1", 4'b0100, G1, 1'b0);
    tick; chk_out("b2b.a2", 4'b0100, G2, 1'b0);
    tick; chk_out("b2b.b_req", 4'b0001, '0, 1'b0);
    tick; chk_out("b2b.b0", 4'b0001, K0, 1'b0);
    tick; chk_out("b2b.b1", 4'b0001, K1, 1'b0);
    tick; drive(1'b0, P0); chk_out("b2b.after", 4'b0000, '0, 1'b0);

    // Grant withdrawn mid-body for three cycles.
    tick; drive(1'b0, P1); chk("stall.req", 32'(bus.req), 32'(4'b0010));
    tick; drive(1'b0, P2);
    tick; drive(1'b0, P3);
    tick; drive(1'b1, '0); chk_out("stall.p0", 4'b0010, P0, 1'b0);
    tick; chk_out("stall.p1", 4'b0010, P1, 1'b0);
    tick; drive(1'b0, '0); chk_out("stall.c0", 4'b0010, '0, 1'b0);
    tick; chk_out("stall.c1", 4'b0010, '0, 1'b0);
    tick; chk_out("stall.c2", 4'b0010, '0, 1'b0);
    tick; drive(1'b1, '0); chk_out("stall.p2", 4'b0010, P2, 1'b0);
    tick; chk_out("stall.p3", 4'b0010, P3, 1'b0);
    tick; chk_out("stall.after", 4'b0000, '0, 1'b0);

    // Reset with a pending head discards it.
    drive(1'b0, H3);
    tick; drive(1'b0, '0); chk("rst.pre_req", 32'(bus.req), 32'(4'b1000));
    rst = 1'b1;
    #1; chk_out("rst.during", 4'b0000, '0, 1'b0);
    tick; rst = 1'b0;
    drive(1'b1, '0); chk_out("rst.after", 4'b0000, '0, 1'b0);
    tick; chk_out("rst.stays", 4'b0000, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
